// File: rtl/mem_bus_arbiter.sv
// Two-port data-memory arbiter: CPU MEM stage vs UART loader, round-robin with burst cap and loader lock.
// Latency: one grant cycle from IDLE, then one access per cycle; CPU<->DMA handover on a single edge.
// Backpressure: a requester holds req until ack; cpu_stall holds the CPU pipeline while it waits.
module mem_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CPU  = 2'b01,
    S_DMA  = 2'b10
  } state_t;

  localparam logic [4:0] BURST_LIM = 5'(MAX_BURST);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_dma_q, last_dma_d;   // 1: loader was served last, 0: CPU was

  logic [4:0] cnt_inc;
  logic       burst_ok;

  // The grant state is the owner code itself, so owner is a plain flop output.
  assign owner = state_q;

  // Acks follow the registered grant; the owner's req is the access strobe.
  assign cpu_ack = (state_q == S_CPU) & cpu_req;
  assign dma_ack = (state_q == S_DMA) & dma_req;

  // Stall is masked by reset so every output is quiet while reset is held.
  assign cpu_stall = reset_b & cpu_req & ~cpu_ack;

  assign cpu_rdata = (cpu_ack & ~cpu_we) ? mem_rdata : '0;
  assign dma_rdata = (dma_ack & ~dma_we) ? mem_rdata : '0;

  // Holder may keep the bus against a waiting rival only while this ack stays under the cap.
  assign cnt_inc  = {1'b0, cnt_q} + 5'd1;
  assign burst_ok = (cnt_inc < BURST_LIM);

  // Memory port mux: the owner's address/data; strobes only alongside that owner's ack.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_CPU: begin
        mem_rd    = cpu_req & ~cpu_we;
        mem_wr    = cpu_req &  cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      S_DMA: begin
        mem_rd    = dma_req & ~dma_we;
        mem_wr    = dma_req &  dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      default: begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

  // Next grant, last-served pointer and tenure counter.
  always_comb begin
    state_d    = state_q;
    last_dma_d = last_dma_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_req && dma_req) begin
          state_d = last_dma_q ? S_CPU : S_DMA;
        end else if (cpu_req) begin
          state_d = S_CPU;
        end else if (dma_req) begin
          state_d = S_DMA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CPU: begin
        if (cpu_req && (!dma_req || burst_ok)) begin
          state_d = S_CPU;
        end else if (dma_req) begin
          state_d = S_DMA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DMA: begin
        if (dma_req && (dma_lock || !cpu_req || burst_ok)) begin
          state_d = S_DMA;
        end else if (cpu_req) begin
          state_d = S_CPU;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cpu_ack) begin
      last_dma_d = 1'b0;
    end else if (dma_ack) begin
      last_dma_d = 1'b1;
    end

    // A new tenure starts from zero; within a tenure count acks, saturating.
    if (state_d != state_q) begin
      cnt_d = 4'd0;
    end else if ((cpu_ack || dma_ack) && (cnt_q != 4'hF)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Arbiter state registers; reset parks in IDLE with the loader marked as served last.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      last_dma_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dma_q <= last_dma_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
// Latency: model predicts every output each cycle; grants are expected one cycle after the request in IDLE.
// Backpressure: requesters hold req until acked, loader lock honoured; wait bound checked when lock is off.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack, cpu_stall;
  logic          dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_b(reset_b),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  // Bench-side data memory (what the DUT drives) and the model's own copy.
  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] ref_mem [0:255];
  int            wr_count = 0;

  assign mem_rdata = mem_rd ? mem[mem_addr[9:2]] : '0;

  always @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_addr[9:2]] = mem_wdata;
      wr_count = wr_count + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who holds the bus, acks in this tenure, who was served last.
  int m_owner;      // 0 none, 1 CPU, 2 loader
  int m_tenure;
  bit m_last_cpu;
  bit e_ca, e_da;

  // Observations of the DUT in the last checked cycle.
  logic [1:0]    obs_owner;
  logic          obs_ca, obs_da, obs_stall;
  logic [DW-1:0] obs_crd;

  bit wait_en = 1'b0;
  int cpu_wait = 0;
  int dma_wait = 0;

  task automatic model_reset();
    m_owner    = 0;
    m_tenure   = 0;
    m_last_cpu = 1'b0;
  endtask

  // Called at posedge+1 with inputs set; checks at mid-cycle, advances the model, returns at next posedge+1.
  task automatic cycle();
    logic [1:0]    e_owner;
    logic          e_rd, e_wr, e_stall;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_crd, e_drd;
    int            nx;
    #4;
    e_ca    = (m_owner == 1) && cpu_req;
    e_da    = (m_owner == 2) && dma_req;
    e_owner = 2'(m_owner);
    e_rd    = (e_ca && !cpu_we) || (e_da && !dma_we);
    e_wr    = (e_ca &&  cpu_we) || (e_da &&  dma_we);
    e_stall = cpu_req && !e_ca;
    e_addr  = (m_owner == 1) ? cpu_addr  : (m_owner == 2) ? dma_addr  : '0;
    e_wd    = (m_owner == 1) ? cpu_wdata : (m_owner == 2) ? dma_wdata : '0;
    e_crd   = (e_ca && !cpu_we) ? ref_mem[cpu_addr[9:2]] : '0;
    e_drd   = (e_da && !dma_we) ? ref_mem[dma_addr[9:2]] : '0;

    chk("owner", owner, e_owner);
    chk("ack_rd_wr_stall", {cpu_ack, dma_ack, mem_rd, mem_wr, cpu_stall},
        {e_ca, e_da, e_rd, e_wr, e_stall});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("cpu_rdata", cpu_rdata, e_crd);
    chk("dma_rdata", dma_rdata, e_drd);
    chk("exclusive", {cpu_ack & dma_ack, mem_rd & mem_wr}, 2'b00);

    obs_owner = owner;
    obs_ca    = cpu_ack;
    obs_da    = dma_ack;
    obs_stall = cpu_stall;
    obs_crd   = cpu_rdata;

    // Fairness: consecutive waiting cycles of each requester, judged on the DUT's own acks.
    if (cpu_stall) cpu_wait++;
    if (cpu_ack) begin
      if (wait_en) chk("cpu_wait_bound", cpu_wait <= MB + 1, 1'b1);
      cpu_wait = 0;
    end
    if (!cpu_req) cpu_wait = 0;
    if (dma_req && !dma_ack) dma_wait++;
    if (dma_ack) begin
      if (wait_en) chk("dma_wait_bound", dma_wait <= MB + 1, 1'b1);
      dma_wait = 0;
    end
    if (!dma_req) dma_wait = 0;

    // Model advance: writes land, tenure counts this ack, then pick the next holder.
    if (e_ca && cpu_we) ref_mem[cpu_addr[9:2]] = cpu_wdata;
    if (e_da && dma_we) ref_mem[dma_addr[9:2]] = dma_wdata;
    if (e_ca || e_da) m_tenure++;
    case (m_owner)
      0: begin
        if (cpu_req && dma_req) nx = m_last_cpu ? 2 : 1;
        else if (cpu_req)       nx = 1;
        else if (dma_req)       nx = 2;
        else                    nx = 0;
      end
      1: begin
        if (cpu_req && (!dma_req || m_tenure < MB)) nx = 1;
        else if (dma_req)                           nx = 2;
        else                                        nx = 0;
      end
      2: begin
        if (dma_req && (dma_lock || !cpu_req || m_tenure < MB)) nx = 2;
        else if (cpu_req)                                       nx = 1;
        else                                                    nx = 0;
      end
      default: nx = 0;
    endcase
    if (e_ca) m_last_cpu = 1'b1;
    if (e_da) m_last_cpu = 1'b0;
    if (nx != m_owner) m_tenure = 0;
    m_owner = nx;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_ack(input bit is_cpu, input string tag);
    bit got = 1'b0;
    for (int n = 0; n < 16 && !got; n++) begin
      cycle();
      got = is_cpu ? obs_ca : obs_da;
    end
    chk(tag, got, 1'b1);
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    @(posedge clk);
    #1;
    reset_b = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_cpu, n_dma, first, w0;
    bit  handed, prev_ca, stall_all;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h1000_0000 + i * 32'h0101;
      ref_mem[i] = 32'h1000_0000 + i * 32'h0101;
    end
    model_reset();

    // Reset: everything quiet even with both requests up.
    cpu_req = 1'b1;
    dma_req = 1'b1;
    #2;
    chk("rst_owner", owner, 2'b00);
    chk("rst_ctl", {cpu_ack, dma_ack, cpu_stall, mem_rd, mem_wr}, 5'b0);
    chk("rst_bus", {mem_addr, mem_wdata}, 64'h0);
    chk("rst_rdata", {cpu_rdata, dma_rdata}, 64'h0);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(posedge clk);
    #1;
    reset_b = 1'b1;
    cycle();

    // Lone CPU read: stall in the grant cycle, ack with memory data next.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h4000_0010;
    cycle();
    chk("r37_grant_cycle_owner", obs_owner, 2'b00);
    chk("r37_grant_cycle_stall", obs_stall, 1'b1);
    cycle();
    chk("r37_owner_cpu", obs_owner, 2'b01);
    chk("r37_ack", obs_ca, 1'b1);
    chk("r37_stall_cleared", obs_stall, 1'b0);
    chk("r37_rdata", obs_crd, 32'h1000_0404);
    cpu_req = 1'b0;
    cycle();

    // Simultaneous requests from reset: CPU first, exactly MB acks, then loader with no bubble.
    do_reset();
    cpu_req  = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0020;
    dma_req  = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0044;
    n_cpu = 0; first = 0; handed = 1'b0; prev_ca = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (first == 0) first = obs_ca ? 1 : (obs_da ? 2 : 0);
      if (obs_da && !handed) begin
        handed = 1'b1;
        chk("r38_no_bubble", prev_ca, 1'b1);
      end
      if (obs_ca && !handed) n_cpu++;
      prev_ca = obs_ca;
    end
    chk("r38_cpu_first", first, 1);
    chk("r38_cpu_burst", n_cpu, MB);
    chk("r38_handover", handed, 1'b1);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    cycle();
    cycle();

    // Locked loader keeps the bus for its whole 20-access run.
    dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b1;
    dma_addr = 32'h0000_0300; dma_wdata = $urandom;
    cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    n_dma = 0; stall_all = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (obs_da) n_dma++;
      if (!obs_stall) stall_all = 1'b0;
    end
    chk("r39_locked_acks", n_dma, 20);
    chk("r39_cpu_stalled", stall_all, 1'b1);
    dma_req = 1'b0;
    cycle();
    chk("r39_release_cycle_owner", obs_owner, 2'b10);
    cycle();
    chk("r39_cpu_owner", obs_owner, 2'b01);
    chk("r39_cpu_ack", obs_ca, 1'b1);
    cpu_req = 1'b0;
    dma_lock = 1'b0;
    cycle();

    // Loader writes a word once, CPU reads it back.
    w0 = wr_count;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0000_0100; dma_wdata = 32'hDEAD_BEEF;
    run_until_ack(1'b0, "r40_dma_write_grant");
    dma_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100;
    run_until_ack(1'b1, "r40_cpu_read_grant");
    chk("r40_readback", obs_crd, 32'hDEAD_BEEF);
    cpu_req = 1'b0;
    cycle();
    chk("r40_single_write", wr_count - w0, 1);

    // Reset in the middle of a loader write tenure with the CPU waiting.
    dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b1;
    dma_addr = 32'h0000_0200; dma_wdata = 32'h1234_5678;
    cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0008;
    cycle();
    w0 = wr_count;
    reset_b = 1'b0;
    #1;
    chk("r41_owner_now", owner, 2'b00);
    chk("r41_wr_now", mem_wr, 1'b0);
    chk("r41_ctl_now", {cpu_ack, dma_ack, cpu_stall, mem_rd}, 4'b0);
    @(posedge clk);
    #1;
    chk("r41_no_write", wr_count - w0, 0);
    reset_b = 1'b1;
    model_reset();
    cycle();
    cycle();
    chk("r41_cpu_first", obs_owner, 2'b01);
    chk("r41_cpu_ack", obs_ca, 1'b1);
    cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
    cycle();
    cycle();

    // Random traffic, loader unlocked; each side holds its request until acked.
    wait_en  = 1'b1;
    cpu_wait = 0;
    dma_wait = 0;
    obs_ca   = 1'b0;
    obs_da   = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!cpu_req || obs_ca) begin
        cpu_req = ($urandom_range(0, 3) != 0);
        cpu_we  = $urandom_range(0, 1) == 1;
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
      end
      if (!dma_req || obs_da) begin
        dma_req = ($urandom_range(0, 3) != 0);
        dma_we  = $urandom_range(0, 1) == 1;
        dma_addr  = $urandom;
        dma_wdata = $urandom;
      end
      cycle();
    end
    wait_en = 1'b0;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of both requester ports and the memory port.
REQ-002 Parameter: DATA_W, 32, data width of write/read data on all ports.
REQ-003 Parameter: MAX_BURST, 4, max consecutive acks granted to one requester while the other is pending (legal range 1..15).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset_b  in  1  reset, asynchronous, active-low.
REQ-006 cpu_req  in  1  CPU MEM-stage access request; held until cpu_ack.
REQ-007 cpu_we  in  1  CPU access is a write (1) or read (0).
REQ-008 cpu_addr, cpu_wdata  in  ADDR_W, DATA_W  CPU address / write data.
REQ-009 cpu_rdata  out  DATA_W  CPU read data, valid in the cycle cpu_ack=1 with cpu_we=0.
REQ-010 cpu_ack  out  1  CPU access performed this cycle.
REQ-011 cpu_stall  out  1  CPU pipeline hold: cpu_req & ~cpu_ack.
REQ-012 dma_req, dma_we, dma_lock  in  1 each  UART-loader request, write flag, grant-lock.
REQ-013 dma_addr, dma_wdata  in  ADDR_W, DATA_W  loader address / write data.
REQ-014 dma_rdata  out  DATA_W  loader read data, valid when dma_ack=1 with dma_we=0.
REQ-015 dma_ack  out  1  loader access performed this cycle.
REQ-016 mem_rd, mem_wr  out  1 each  data-memory read / write strobes.
REQ-017 mem_addr, mem_wdata  out  ADDR_W, DATA_W  data-memory address / write data.
REQ-018 mem_rdata  in  DATA_W  data-memory read data (combinational from mem_addr/mem_rd).
REQ-019 owner  out  2  current grant state: 00 IDLE, 01 CPU, 10 DMA.

Function
REQ-020 States IDLE, CPU, DMA held in a registered FSM; owner reflects the state directly.
REQ-021 In IDLE: no ack, mem_rd=mem_wr=0, mem_addr/mem_wdata=0.
REQ-022 In CPU: mem port driven from cpu_* ; mem_rd=cpu_req&~cpu_we, mem_wr=cpu_req&cpu_we, cpu_ack=cpu_req, dma_ack=0.
REQ-023 In DMA: symmetric with dma_* ; cpu_ack=0.
REQ-024 Requester rdata outputs = mem_rdata when that requester is acked for a read, else 0.
REQ-025 Arbitration latency: a request arriving in IDLE is acked no earlier than the following cycle (one grant cycle).
REQ-026 IDLE next state: only cpu_req -> CPU; only dma_req -> DMA; both -> the requester not served last (last pointer); neither -> IDLE.
REQ-027 Last pointer updated to the owner on every ack; reset value DMA, so CPU wins the first simultaneous request.
REQ-028 Burst counter cnt (4 bits) counts acks in the current tenure; cleared on every state change; saturates at 15.
REQ-029 CPU next state: cpu_req and (~dma_req or cnt+1 < MAX_BURST) -> CPU; else dma_req -> DMA; else IDLE.
REQ-030 DMA next state: dma_req and (dma_lock or ~cpu_req or cnt+1 < MAX_BURST) -> DMA; else cpu_req -> CPU; else IDLE.
REQ-031 Handover between CPU and DMA occurs on a single clock edge, no IDLE bubble.
REQ-032 Requester dropping req while owner (no ack that cycle) releases grant at the next edge per REQ-029/030.
REQ-033 A write is performed exactly once per ack; no mem_wr strobe is ever asserted without the matching ack.
REQ-034 At most one of cpu_ack, dma_ack is 1 in any cycle; mem_rd and mem_wr never both 1.

Reset
REQ-035 reset_b=0 asynchronously forces state IDLE, cnt=0, last=DMA; all outputs 0 while reset is asserted.
REQ-036 Reset mid-tenure abandons the access; no write strobe is issued in the reset cycle; after release arbitration restarts from IDLE.

Verification
REQ-037 cpu_req read addr 0x40000010 alone -> owner=01 next cycle, cpu_ack=1, cpu_rdata=mem_rdata, cpu_stall=1 only in the first cycle.
REQ-038 cpu_req and dma_req asserted together from reset -> CPU acked first; CPU continuous requests get exactly 4 acks, then owner=10 on next edge with no bubble.
REQ-039 dma_lock=1 with dma_req held 20 cycles and cpu_req pending -> 20 consecutive dma_acks, cpu_stall=1 throughout, CPU granted on the edge after dma_req drops.
REQ-040 dma write data 0xDEADBEEF to 0x00000100 then CPU read of 0x00000100 -> mem_wr pulses once, CPU reads 0xDEADBEEF.
REQ-041 reset_b pulsed low during DMA write tenure -> owner=00, mem_wr=0 immediately; after release, pending cpu_req granted first.
REQ-042 Random req/we traffic 10k cycles -> REQ-034 never violated; neither requester waits more than MAX_BURST+1 cycles while the other has dma_lock=0.
